// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low key matrix, debounces a single key
// and presents it as a key code (button) plus a debounced held level (bstate).
// button is only updated on press acceptance, so it stays stable across the
// falling edge of bstate.
// Optional build macro KEYPAD_COL_SYNC_EN: two-flop column synchronizer
// instead of a single input register (adds one cycle of latency).
module keypad_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_strobe
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DB_PRESS,
        ST_HELD,
        ST_DB_REL
    } state_t;

    logic [3:0] cs_q;

`ifdef KEYPAD_COL_SYNC_EN
    logic [3:0] sync_q;

    // Two-flop synchronizer on the column inputs; idle (all released) in reset.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            sync_q <= 4'hF;
            cs_q   <= 4'hF;
        end else begin
            sync_q <= col_in;
            cs_q   <= sync_q;
        end
    end
`else
    // Single input register on the column inputs; idle (all released) in reset.
    always_ff @(posedge hwclk) begin
        if (reset) cs_q <= 4'hF;
        else       cs_q <= col_in;
    end
`endif

    state_t          state_q, state_d;
    logic [1:0]      row_q, row_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      button_q, button_d;
    logic            bstate_q, bstate_d;
    logic            strobe_q, strobe_d;
    logic [1:0]      low_col;

    // Lowest-index pressed column on the currently sampled row.
    always_comb begin
        low_col = 2'd3;
        if      (!cs_q[0]) low_col = 2'd0;
        else if (!cs_q[1]) low_col = 2'd1;
        else if (!cs_q[2]) low_col = 2'd2;
    end

    // Next-state logic. Counters never pass their terminal value because the
    // terminal compare always moves the FSM on and clears them.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        scan_cnt_d = scan_cnt_q;
        db_cnt_d   = db_cnt_q;
        cand_d     = cand_q;
        button_d   = button_q;
        bstate_d   = bstate_q;
        strobe_d   = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (&cs_q) begin
                        row_d = 2'(row_q + 2'd1);
                    end else begin
                        cand_d   = {row_q, low_col};
                        db_cnt_d = '0;
                        state_d  = ST_DB_PRESS;
                    end
                end else begin
                    scan_cnt_d = SW'(scan_cnt_q + SW'(1));
                end
            end
            ST_DB_PRESS: begin
                if (cs_q[cand_q[1:0]]) begin
                    // Bounced: rescan the same row from a fresh dwell.
                    state_d    = ST_SCAN;
                    scan_cnt_d = '0;
                    db_cnt_d   = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    button_d = cand_q;
                    db_cnt_d = '0;
                    state_d  = ST_HELD;
                end else begin
                    db_cnt_d = DW'(db_cnt_q + DW'(1));
                end
            end
            ST_HELD: begin
                // bstate rises one cycle after button was loaded.
                bstate_d = 1'b1;
                if (&cs_q) begin
                    db_cnt_d = '0;
                    state_d  = ST_DB_REL;
                end
            end
            ST_DB_REL: begin
                if (!(&cs_q)) begin
                    db_cnt_d = '0;
                    state_d  = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    bstate_d   = 1'b0;
                    strobe_d   = 1'b1;
                    db_cnt_d   = '0;
                    scan_cnt_d = '0;
                    row_d      = 2'(row_q + 2'd1);
                    state_d    = ST_SCAN;
                end else begin
                    db_cnt_d = DW'(db_cnt_q + DW'(1));
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // State register; reset overrides everything, including a release strobe.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            cand_q     <= 4'd0;
            button_q   <= 4'd0;
            bstate_q   <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            scan_cnt_q <= scan_cnt_d;
            db_cnt_q   <= db_cnt_d;
            cand_q     <= cand_d;
            button_q   <= button_d;
            bstate_q   <= bstate_d;
            strobe_q   <= strobe_d;
        end
    end

    // One-cold row drive decoded from the row index.
    always_comb begin
        row_out = ~(4'b0001 << row_q);
    end

    assign button     = button_q;
    assign bstate     = bstate_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad matrix model drives col_in from row_out
// and a per-cycle key timeline; expected event cycles are derived from the
// timeline with window searches over scan phase and debounce length.
module tb_keypad_encoder;

    localparam int SD   = 4;
    localparam int DB   = 8;
    localparam int MAXC = 4000;
`ifdef KEYPAD_COL_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       hwclk = 1'b0;
    logic       reset;
    logic [3:0] col_in, row_out, button;
    logic       bstate, key_strobe;

    logic [15:0] keys;
    logic [15:0] kh [0:MAXC];
    logic [3:0]  lb [0:MAXC];
    logic [3:0]  lr [0:MAXC];
    logic        ls [0:MAXC];
    logic        lk [0:MAXC];
    int cyc, n_chk, n_fail, e0, r0, prev;

    always #5 hwclk = ~hwclk;

    keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .hwclk(hwclk), .reset(reset), .col_in(col_in), .row_out(row_out),
        .button(button), .bstate(bstate), .key_strobe(key_strobe)
    );

    // Passive matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_out[r] == 1'b0 && keys[r*4+c]) col_in[c] = 1'b0;
    end

    task automatic tick();
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget: cyc=%0d limit=%0d", cyc, MAXC - 2);
            $fatal(1);
        end
        @(posedge hwclk);
        cyc++;
        @(negedge hwclk);
        lb[cyc] = button; ls[cyc] = bstate; lk[cyc] = key_strobe; lr[cyc] = row_out;
        keys = kh[cyc+1];
    endtask

    task automatic set_key(input int k, input int from, input int to, input bit v);
        for (int n = from; n <= to && n <= MAXC; n++) kh[n][k] = v;
    endtask

    function automatic bit pressed(input int n, input int k);
        return (n >= 0 && n <= MAXC) ? kh[n][k] : 1'b0;
    endfunction

    function automatic bit row_idle(input int n, input int r);
        return (n < 0 || n > MAXC) ? 1'b1 : (((kh[n] >> (4*r)) & 16'hF) == 16'h0);
    endfunction

    function automatic int scan_row(input int n);
        return (r0 + (n - e0 - 1) / SD) % 4;
    endfunction

    // Edge at which key k is accepted: first dwell-end sample of k's row that
    // sees it, followed by DB cycles of it staying down; a bounce restarts the
    // dwell on the same row.
    function automatic int predict_accept(input int k);
        int o, ro, n, m;
        bit ok;
        o = e0; ro = r0; n = e0 + 1;
        while (n < MAXC - 20) begin
            if (((n - o - 1) % SD) == SD - 1 && ((ro + (n - o - 1) / SD) % 4) == k / 4
                && pressed(n - L, k)) begin
                ok = 1'b1;
                for (m = n + 1; m <= n + DB; m++)
                    if (!pressed(m - L, k)) begin ok = 1'b0; break; end
                if (ok) return n + DB;
                o = m; ro = k / 4; n = m + 1;
            end else begin
                n++;
            end
        end
        return -1;
    endfunction

    // Edge at which bstate falls: DB consecutive idle samples of the frozen row.
    function automatic int predict_release(input int k, input int a);
        int r, c, m;
        bit ok;
        r = k / 4; c = a + 1;
        while (c < MAXC - 20) begin
            if (row_idle(c - L, r)) begin
                ok = 1'b1;
                for (m = c + 1; m <= c + DB; m++)
                    if (!row_idle(m - L, r)) begin ok = 1'b0; break; end
                if (ok) return c + DB;
                c = m + 1;
            end else begin
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int count_strobes(input int from, input int to);
        int s = 0;
        for (int n = from; n <= to; n++) if (lk[n] === 1'b1) s++;
        return s;
    endfunction

    task automatic test_reset();
        logic [3:0] er;
        reset = 1'b1;
        repeat (3) @(posedge hwclk);
        @(negedge hwclk);
        n_chk++;
        if (row_out !== 4'b1110 || button !== 4'd0 || bstate !== 1'b0 || key_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: row=%b btn=%0d bst=%b stb=%b, want 1110/0/0/0",
                     row_out, button, bstate, key_strobe);
        end
        reset = 1'b0; cyc = 0; e0 = 0; r0 = 0; prev = 0;
        lb[0] = button; ls[0] = bstate; lk[0] = key_strobe; lr[0] = row_out;
        keys = kh[1];
        repeat (40) tick();
        for (int n = 0; n <= 40; n++) begin
            er = ~(4'b0001 << scan_row(n + 1));
            n_chk++;
            if (lr[n] !== er || ls[n] !== 1'b0 || lk[n] !== 1'b0 || lb[n] !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_scan@%0d: row=%b bst=%b stb=%b btn=%0d, want row=%b 0/0/0",
                         n, lr[n], ls[n], lk[n], lb[n], er);
            end
        end
    endtask

    task automatic test_press_release();
        int s, a, f, k;
        bit held_ok;
        logic [3:0] er;
        k = 9; s = cyc + 2;
        set_key(k, s, s + 39, 1'b1);
        a = predict_accept(k);
        f = (a < 0) ? -1 : predict_release(k, a);
        if (a < 0 || f < 0) begin $display("FAIL press_window: a=%0d f=%0d", a, f); $fatal(1); end
        while (cyc < f + 3) tick();
        n_chk++;
        if (lb[a-1] !== 4'(prev) || ls[a-1] !== 1'b0) begin
            n_fail++; $display("FAIL pr_before: btn=%0d bst=%b, want %0d/0", lb[a-1], ls[a-1], prev);
        end
        n_chk++;
        if (lb[a] !== 4'd9 || ls[a] !== 1'b0) begin
            n_fail++; $display("FAIL pr_button_setup: btn=%0d bst=%b, want 9/0", lb[a], ls[a]);
        end
        n_chk++;
        if (ls[a+1] !== 1'b1) begin
            n_fail++; $display("FAIL pr_bstate_rise: bst=%b, want 1", ls[a+1]);
        end
        held_ok = 1'b1;
        for (int n = a + 1; n < f; n++) if (ls[n] !== 1'b1 || lb[n] !== 4'd9) held_ok = 1'b0;
        n_chk++;
        if (!held_ok) begin n_fail++; $display("FAIL pr_held: got a drop or button change, want stable 9"); end
        n_chk++;
        if (ls[f] !== 1'b0 || lk[f] !== 1'b1 || lb[f] !== 4'd9) begin
            n_fail++; $display("FAIL pr_release: bst=%b stb=%b btn=%0d, want 0/1/9", ls[f], lk[f], lb[f]);
        end
        n_chk++;
        if (lk[f+1] !== 1'b0 || lb[f+1] !== 4'd9 || ls[f+1] !== 1'b0) begin
            n_fail++; $display("FAIL pr_after: stb=%b btn=%0d bst=%b, want 0/9/0", lk[f+1], lb[f+1], ls[f+1]);
        end
        n_chk++;
        if (count_strobes(s, f + 3) != 1) begin
            n_fail++; $display("FAIL pr_strobe_count: %0d, want 1", count_strobes(s, f + 3));
        end
        er = ~(4'b0001 << ((k / 4 + 1) % 4));
        n_chk++;
        if (lr[f] !== er) begin n_fail++; $display("FAIL pr_next_row: row=%b, want %b", lr[f], er); end
        e0 = f; r0 = (k / 4 + 1) % 4; prev = k;
    endtask

    task automatic test_bounce();
        int n, a, f, k;
        bit quiet;
        k = 3;
        n = cyc + L + 3;
        while (!(((n - e0 - 1) % SD) == SD - 1 && scan_row(n) == 0)) n++;
        set_key(k, n - L - 1, n - L + 1, 1'b1);
        set_key(k, n - L + 2, n - L + 2, 1'b0);
        set_key(k, n - L + 3, n - L + 40, 1'b1);
        a = predict_accept(k);
        f = (a < 0) ? -1 : predict_release(k, a);
        if (a < 0 || f < 0) begin $display("FAIL bounce_window: a=%0d f=%0d", a, f); $fatal(1); end
        while (cyc < f + 3) tick();
        quiet = 1'b1;
        for (int m = n - L - 1; m <= a; m++) if (ls[m] !== 1'b0) quiet = 1'b0;
        n_chk++;
        if (!quiet) begin n_fail++; $display("FAIL bounce_quiet: bstate rose before %0d, want 0", a + 1); end
        n_chk++;
        if (lb[a-1] !== 4'(prev) || lb[a] !== 4'd3) begin
            n_fail++; $display("FAIL bounce_accept: btn %0d->%0d, want %0d->3", lb[a-1], lb[a], prev);
        end
        n_chk++;
        if (ls[a+1] !== 1'b1 || ls[f] !== 1'b0 || lk[f] !== 1'b1 || lb[f] !== 4'd3) begin
            n_fail++;
            $display("FAIL bounce_cycle: rise=%b fall=%b stb=%b btn=%0d, want 1/0/1/3",
                     ls[a+1], ls[f], lk[f], lb[f]);
        end
        e0 = f; r0 = (k / 4 + 1) % 4; prev = k;
    endtask

    task automatic test_multi_key();
        int s, a, f, p;
        bit btn_ok;
        s = cyc + 2;
        set_key(9, s, s + 100, 1'b1);
        a = predict_accept(9);
        if (a < 0) begin $display("FAIL multi_window: a=%0d", a); $fatal(1); end
        p = a + 20;
        set_key(9, p + 1, s + 100, 1'b0);
        set_key(12, a + 2, p, 1'b1);
        f = predict_release(9, a);
        if (f < 0) begin $display("FAIL multi_window: f=%0d", f); $fatal(1); end
        while (cyc < f + 20) tick();
        btn_ok = 1'b1;
        for (int n = a; n <= f + 20; n++) if (lb[n] !== 4'd9) btn_ok = 1'b0;
        n_chk++;
        if (!btn_ok) begin n_fail++; $display("FAIL multi_button: changed while 9 held, want 9"); end
        n_chk++;
        if (ls[a+1] !== 1'b1 || ls[f-1] !== 1'b1 || ls[f] !== 1'b0) begin
            n_fail++; $display("FAIL multi_bstate: %b/%b/%b, want 1/1/0", ls[a+1], ls[f-1], ls[f]);
        end
        n_chk++;
        if (count_strobes(s, f + 20) != 1 || lk[f] !== 1'b1) begin
            n_fail++; $display("FAIL multi_strobes: %0d (at fall %b), want 1", count_strobes(s, f + 20), lk[f]);
        end
        e0 = f; r0 = (9 / 4 + 1) % 4; prev = 9;
    endtask

    task automatic test_reset_held();
        int s, a, rc;
        bit idle_ok;
        logic [3:0] er;
        s = cyc + 2;
        set_key(5, s, s + 200, 1'b1);
        a = predict_accept(5);
        if (a < 0) begin $display("FAIL rh_window: a=%0d", a); $fatal(1); end
        while (cyc < a + 4) tick();
        n_chk++;
        if (lb[cyc] !== 4'd5 || ls[cyc] !== 1'b1) begin
            n_fail++; $display("FAIL rh_held: btn=%0d bst=%b, want 5/1", lb[cyc], ls[cyc]);
        end
        set_key(5, cyc + 1, s + 200, 1'b0);
        keys = kh[cyc+1];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rc = cyc;
        n_chk++;
        if (lr[rc] !== 4'b1110 || lb[rc] !== 4'd0 || ls[rc] !== 1'b0 || lk[rc] !== 1'b0) begin
            n_fail++;
            $display("FAIL rh_reset: row=%b btn=%0d bst=%b stb=%b, want 1110/0/0/0",
                     lr[rc], lb[rc], ls[rc], lk[rc]);
        end
        e0 = rc; r0 = 0; prev = 0;
        repeat (20) tick();
        idle_ok = 1'b1;
        for (int n = rc; n <= cyc; n++) begin
            er = ~(4'b0001 << scan_row(n + 1));
            if (lk[n] !== 1'b0 || ls[n] !== 1'b0 || lr[n] !== er) idle_ok = 1'b0;
        end
        n_chk++;
        if (!idle_ok) begin n_fail++; $display("FAIL rh_after: strobe/bstate/row off after reset, want idle scan"); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int k, s, h, a, f, g;
            bit held_ok;
            k = $urandom_range(0, 15);
            s = cyc + 2 + $urandom_range(0, 10);
            h = $urandom_range(60, 80);
            set_key(k, s, s + h - 1, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                g = s + $urandom_range(1, 19);
                kh[g][k] = 1'b0;
            end
            a = predict_accept(k);
            f = (a < 0) ? -1 : predict_release(k, a);
            if (a < 0 || f < 0) begin $display("FAIL rnd_window: key=%0d a=%0d f=%0d", k, a, f); $fatal(1); end
            while (cyc < f + 3) tick();
            n_chk++;
            if (lb[a-1] !== 4'(prev) || lb[a] !== 4'(k) || ls[a] !== 1'b0 || ls[a+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_accept key=%0d: btn %0d->%0d bst %b->%b, want %0d->%0d 0->1",
                         k, lb[a-1], lb[a], ls[a], ls[a+1], prev, k);
            end
            held_ok = 1'b1;
            for (int n = a + 1; n < f; n++) if (ls[n] !== 1'b1 || lb[n] !== 4'(k)) held_ok = 1'b0;
            n_chk++;
            if (!held_ok) begin n_fail++; $display("FAIL rnd_held key=%0d: bstate/button unstable", k); end
            n_chk++;
            if (ls[f] !== 1'b0 || lk[f] !== 1'b1 || lb[f+1] !== 4'(k) || count_strobes(s, f + 3) != 1) begin
                n_fail++;
                $display("FAIL rnd_release key=%0d: bst=%b stb=%b btn=%0d strobes=%0d, want 0/1/%0d/1",
                         k, ls[f], lk[f], lb[f+1], count_strobes(s, f + 3), k);
            end
            e0 = f; r0 = (k / 4 + 1) % 4; prev = k;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; keys = '0; reset = 1'b1;
        for (int n = 0; n <= MAXC; n++) kh[n] = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_multi_key();
        test_random();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
